c2h_pkt_packer: RTL and testbench
=================================

Name: c2h_pkt_packer

Overview:
- Downstream of the traffic generator. Accepts its 512-bit beat stream (valid/ready/ben/last) and converts it into QDMA C2H stream beats.
- Each output packet carries its byte length on every beat and an empty-byte count on the last beat. One completion entry is issued per packet.
- Works store-and-forward: a packet is not forwarded until its last beat is buffered, because QDMA needs the length with the first beat.

Parameters:
- DATA_WIDTH, 512: beat width in bits; byte lanes BEN = DATA_WIDTH/8.
- FIFO_DEPTH, 128: beat FIFO depth in beats (power of 2); also the length-FIFO depth.
- LEN_BITS, 16: width of packet length fields.
- QID_BITS, 11: queue ID width.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid (generator rx_valid).
- s_ready  out  1  input beat accept (drives generator rx_ready).
- s_data  in  DATA_WIDTH  input beat data.
- s_ben  in  BEN  byte enables, contiguous from bit 0.
- s_last  in  1  last beat of packet.
- qid_in  in  QID_BITS  target queue, sampled when a packet starts output.
- m_tvalid  out  1  C2H beat valid.
- m_tready  in  1  C2H beat accept.
- m_tdata  out  DATA_WIDTH  C2H data.
- m_tlast  out  1  C2H last beat.
- m_mty  out  6  empty bytes on last beat; 0 otherwise.
- m_len  out  LEN_BITS  packet byte length, held for all beats of the packet.
- m_qid  out  QID_BITS  packet queue ID.
- cmpt_valid  out  1  completion valid.
- cmpt_ready  in  1  completion accept.
- cmpt_len  out  LEN_BITS  completed packet byte length.
- cmpt_pkt_id  out  16  packet sequence number.
- pkt_cnt  out  32  completed packets.
- byte_cnt  out  32  completed bytes.
- err_oversize  out  1  sticky; an input packet exceeded FIFO_DEPTH beats.

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0; FIFOs empty; length accumulator 0; FSM in IDLE; pkt_id 0; counters 0; err_oversize 0.
- Reset mid-packet discards all partial and buffered data.

Input side:
- s_ready = beat FIFO not full, computed from registered occupancy. On a full FIFO, push is refused even if a pop occurs in the same cycle.
- Input handshake (s_valid & s_ready): push {data, ben, last_eff}; acc += popcount(s_ben), so a zero-ben beat adds 0 bytes.
- in_beats counts beats of the current input packet.
- last_eff = s_last | (in_beats == FIFO_DEPTH-1). The forced case sets err_oversize and splits the packet at FIFO_DEPTH beats.
- When last_eff is handshaken: push acc + popcount(s_ben) into the length FIFO, then clear acc and in_beats.
- Length arithmetic is LEN_BITS wide and truncates on overflow.

Output FSM:
- IDLE: if the length FIFO is non-empty, pop it into m_len, latch m_qid <= qid_in, go to STREAM.
- STREAM: m_tvalid = beat FIFO non-empty; m_tdata and m_tlast come from the FIFO head.
  - m_mty = m_tlast ? BEN - popcount(head ben) : 0.
  - Pop on m_tvalid & m_tready.
  - A handshake with m_tlast goes to CMPT.
- CMPT: cmpt_valid = 1, cmpt_len = m_len, cmpt_pkt_id = pkt_id; m_tvalid = 0.
  - On cmpt_ready: pkt_id++, pkt_cnt++, byte_cnt += m_len, go to IDLE. All three wrap silently.
- Latency: with the input last beat accepted at edge E0, the length FIFO is non-empty after E0. IDLE pops at E1, and m_tvalid is high after E1 (2 cycles).
- Packets leave in input order.
- The next packet cannot start until the previous completion is accepted. Input may keep filling the FIFO meanwhile.

Test Plan:
- 128-byte packet, 2 full beats, m_tready=1, cmpt_ready=1 -> m_len=128 on both beats; m_mty=0; m_tlast on beat 2; cmpt_len=128, cmpt_pkt_id=0; m_tvalid rises 2 cycles after the s_last handshake; pkt_cnt=1, byte_cnt=128.
- 100-byte packet: beat 1 ben all ones, beat 2 ben=0xF_FFFF_FFFF (36 bytes) -> m_len=100, m_mty=28 on last beat only, cmpt_len=100.
- FIFO_DEPTH=16, m_tready=0, four 4-beat packets -> s_ready falls after the 16th beat. Release m_tready -> 4 packets out in order, cmpt_pkt_id 0..3, pkt_cnt=4, byte_cnt=1024.
- FIFO_DEPTH=16, 20-beat full-ben packet -> err_oversize=1 at beat 16. First output packet m_len=1024 with tlast on beat 16; second packet m_len=256; err_oversize stays 1.
- cmpt_ready=0 for 10 cycles after a tlast handshake, second packet already buffered -> cmpt_valid held, cmpt fields stable, no m_tvalid, pkt_cnt unchanged. After cmpt_ready=1: pkt_cnt++, second packet's first beat appears within 2 cycles.
- Assert axi_areset during beat 2 of a 3-beat packet -> all outputs 0 immediately, counters 0. A new 64-byte packet after release gives cmpt_pkt_id=0, cmpt_len=64.

Source files
------------

// File: rtl/c2h_pkt_packer.sv
// c2h_pkt_packer: store-and-forward packer from generator beats to QDMA C2H stream beats plus one completion per packet
module c2h_pkt_packer #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 128,
  parameter int LEN_BITS = 16,
  parameter int QID_BITS = 11
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_ben,
  input  logic                    s_last,
  input  logic [QID_BITS-1:0]     qid_in,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tlast,
  output logic [5:0]              m_mty,
  output logic [LEN_BITS-1:0]     m_len,
  output logic [QID_BITS-1:0]     m_qid,
  output logic                    cmpt_valid,
  input  logic                    cmpt_ready,
  output logic [LEN_BITS-1:0]     cmpt_len,
  output logic [15:0]             cmpt_pkt_id,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             byte_cnt,
  output logic                    err_oversize
);
  localparam int BEN = DATA_WIDTH / 8;
  localparam int PCW = $clog2(BEN) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, STREAM, CMPT} state_t;
  function automatic logic [PCW-1:0] popcount(input logic [BEN-1:0] b);
    popcount = '0;
    for (int i = 0; i < BEN; i++) popcount = popcount + PCW'(b[i]);
  endfunction
  logic [1:0] rst_sync;
  logic rst;
  logic [DATA_WIDTH+BEN:0] mem [FIFO_DEPTH];
  logic [LEN_BITS-1:0] len_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, lwr_ptr, lrd_ptr, in_beats;
  logic [AW:0] cnt, lcnt;
  logic [LEN_BITS-1:0] acc, pkt_len;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BEN-1:0] head_ben;
  logic [PCW-1:0] mty_full;
  logic head_last, push, pop, lpop, last_eff, cmpt_fire;
  state_t state, state_nx;
  // reset asserts asynchronously but releases two clocks later, in step with axi_aclk
  always_ff @(posedge axi_aclk or posedge axi_areset)
    if (axi_areset) rst_sync <= '1;
    else rst_sync <= {rst_sync[0], 1'b0};
  assign rst = rst_sync[1];
  assign s_ready = !rst && cnt != (AW+1)'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign last_eff = s_last || in_beats == AW'(FIFO_DEPTH - 1);
  assign pkt_len = acc + LEN_BITS'(popcount(s_ben));
  assign {head_last, head_ben, head_data} = mem[rd_ptr];
  assign mty_full = PCW'(BEN) - popcount(head_ben);
  assign m_tvalid = state == STREAM && cnt != '0;
  assign m_tdata = m_tvalid ? head_data : '0;
  assign m_tlast = m_tvalid && head_last;
  assign m_mty = m_tlast ? 6'(mty_full) : '0;
  assign pop = m_tvalid && m_tready;
  assign lpop = state == IDLE && lcnt != '0;
  assign cmpt_valid = state == CMPT;
  assign cmpt_fire = cmpt_valid && cmpt_ready;
  assign cmpt_len = m_len;
  always_comb begin
    state_nx = lpop ? STREAM : (pop && head_last) ? CMPT : cmpt_fire ? IDLE : state;
  end
  always_ff @(posedge axi_aclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge axi_aclk) begin
    if (push) mem[wr_ptr] <= {last_eff, s_ben, s_data};
    if (push && last_eff) len_mem[lwr_ptr] <= pkt_len;
  end
  always_ff @(posedge axi_aclk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      lwr_ptr <= '0;
      lrd_ptr <= '0;
      lcnt <= '0;
      in_beats <= '0;
      acc <= '0;
      m_len <= '0;
      m_qid <= '0;
      cmpt_pkt_id <= '0;
      pkt_cnt <= '0;
      byte_cnt <= '0;
      err_oversize <= 1'b0;
    end else begin
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      lcnt <= lcnt + (AW+1)'(push && last_eff) - (AW+1)'(lpop);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        acc <= last_eff ? '0 : pkt_len;
        in_beats <= last_eff ? '0 : in_beats + AW'(1);
        if (last_eff) lwr_ptr <= lwr_ptr + AW'(1);
        if (last_eff && !s_last) err_oversize <= 1'b1;
      end
      if (lpop) begin
        lrd_ptr <= lrd_ptr + AW'(1);
        m_len <= len_mem[lrd_ptr];
        m_qid <= qid_in;
      end
      if (cmpt_fire) begin
        cmpt_pkt_id <= cmpt_pkt_id + 16'd1;
        pkt_cnt <= pkt_cnt + 32'd1;
        byte_cnt <= byte_cnt + 32'(m_len);
      end
    end
endmodule

// File: tb/tb_c2h_pkt_packer.sv
// tb_c2h_pkt_packer: table-driven packets plus hand sequences, checked by an output-beat and completion scoreboard
module tb_c2h_pkt_packer;
  localparam int DW = 512, DEPTH = 16, LB = 16, QB = 11;
  localparam logic [QB-1:0] QID = 11'h2A5;
  logic axi_aclk = 1'b0, axi_areset = 1'b1;
  logic s_valid, s_ready, s_last, m_tvalid, m_tready, m_tlast, cmpt_valid, cmpt_ready, err_oversize;
  logic [DW-1:0] s_data, m_tdata;
  logic [63:0] s_ben;
  logic [QB-1:0] qid_in, m_qid;
  logic [5:0] m_mty;
  logic [LB-1:0] m_len, cmpt_len;
  logic [15:0] cmpt_pkt_id;
  logic [31:0] pkt_cnt, byte_cnt;
  always #5 axi_aclk = ~axi_aclk;
  c2h_pkt_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_BITS(LB), .QID_BITS(QB)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ben(s_ben), .s_last(s_last),
    .qid_in(qid_in),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_mty(m_mty), .m_len(m_len), .m_qid(m_qid),
    .cmpt_valid(cmpt_valid), .cmpt_ready(cmpt_ready), .cmpt_len(cmpt_len), .cmpt_pkt_id(cmpt_pkt_id),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_oversize(err_oversize)
  );
  typedef struct { logic [DW-1:0] data; logic last; logic [5:0] mty; logic [LB-1:0] len; } beat_t;
  typedef struct { logic [LB-1:0] len; logic [15:0] id; } cmpt_t;
  typedef struct { int beats; int last_bytes; int len; int mty; } vec_t;
  beat_t pend[$], exp_q[$];
  cmpt_t cmp_q[$];
  int n_cmp = 0, n_bad = 0, next_id = 0, exp_pkts = 0, exp_bytes = 0;
  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [63:0] ben_of(int n);
    ben_of = '0;
    for (int i = 0; i < n; i++) ben_of[i] = 1'b1;
  endfunction
  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask
  task automatic send_beat(int bytes, logic last);
    beat_t b;
    int t = 0;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    b.last = 1'b0;
    b.mty = '0;
    b.len = '0;
    s_data = b.data;
    s_ben = ben_of(bytes);
    s_last = last;
    s_valid = 1'b1;
    while (!s_ready && t < 1000) begin
      tick();
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    pend.push_back(b);
  endtask
  function automatic void close_pkt(int len, int mty);
    cmpt_t c;
    foreach (pend[i]) begin
      pend[i].last = i == pend.size() - 1;
      pend[i].len = LB'(len);
      pend[i].mty = pend[i].last ? 6'(mty) : 6'd0;
      exp_q.push_back(pend[i]);
    end
    pend.delete();
    c.len = LB'(len);
    c.id = 16'(next_id);
    cmp_q.push_back(c);
    next_id++;
    exp_pkts++;
    exp_bytes += len;
  endfunction
  task automatic send_pkt(int beats, int last_bytes, int len, int mty);
    for (int i = 0; i < beats; i++) send_beat(i == beats - 1 ? last_bytes : 64, i == beats - 1);
    close_pkt(len, mty);
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || cmp_q.size() != 0) && t < 2000) begin
      tick();
      t++;
    end
    chk("drain_left", exp_q.size() + cmp_q.size(), 0);
  endtask
  always @(negedge axi_aclk) begin : mon
    beat_t e;
    cmpt_t c;
    if (!axi_areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", m_tdata, e.data);
        chk("tlast", m_tlast, e.last);
        chk("mty", m_mty, e.mty);
        chk("m_len", m_len, e.len);
        chk("m_qid", m_qid, QID);
      end
    end
    if (!axi_areset && cmpt_valid && cmpt_ready) begin
      if (cmp_q.size() == 0) chk("unexpected_cmpt", 1, 0);
      else begin
        c = cmp_q.pop_front();
        chk("cmpt_len", cmpt_len, c.len);
        chk("cmpt_pkt_id", cmpt_pkt_id, c.id);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[7];
    int t, id_a;
    s_valid = 1'b0;
    s_data = '0;
    s_ben = '0;
    s_last = 1'b0;
    qid_in = QID;
    m_tready = 1'b1;
    cmpt_ready = 1'b1;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_cmpt_valid", cmpt_valid, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err_oversize, 0);
    axi_areset = 1'b0;
    repeat (4) tick();
    chk("s_ready_after_rst", s_ready, 1);
    send_pkt(2, 64, 128, 0);
    chk("tvalid_after_E0", m_tvalid, 0);
    tick();
    chk("tvalid_after_E1", m_tvalid, 1);
    wait_idle();
    chk("pkt_cnt_first", pkt_cnt, 1);
    chk("byte_cnt_first", byte_cnt, 128);
    tbl = '{'{2, 36, 100, 28}, '{1, 1, 1, 63}, '{3, 64, 192, 0}, '{1, 64, 64, 0},
            '{4, 10, 202, 54}, '{16, 64, 1024, 0}, '{2, 64, 128, 0}};
    for (int i = 0; i < 7; i++) send_pkt(tbl[i].beats, tbl[i].last_bytes, tbl[i].len, tbl[i].mty);
    wait_idle();
    chk("pkt_cnt_table", pkt_cnt, exp_pkts);
    chk("byte_cnt_table", byte_cnt, exp_bytes);
    chk("err_exact_depth", err_oversize, 0);
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (p * 4 + b == 15) chk("s_ready_15", s_ready, 1);
        send_beat(64, b == 3);
      end
      close_pkt(256, 0);
    end
    chk("s_ready_full", s_ready, 0);
    repeat (3) tick();
    chk("s_ready_full_held", s_ready, 0);
    chk("pkt_cnt_stalled", pkt_cnt, exp_pkts - 4);
    m_tready = 1'b1;
    wait_idle();
    chk("pkt_cnt_bp", pkt_cnt, exp_pkts);
    chk("byte_cnt_bp", byte_cnt, exp_bytes);
    for (int b = 0; b < 20; b++) begin
      send_beat(64, b == 19);
      if (b == 14) chk("err_before_16", err_oversize, 0);
      if (b == 15) begin
        chk("err_at_16", err_oversize, 1);
        close_pkt(1024, 0);
      end
    end
    close_pkt(256, 0);
    wait_idle();
    chk("err_sticky", err_oversize, 1);
    chk("byte_cnt_oversize", byte_cnt, exp_bytes);
    cmpt_ready = 1'b0;
    id_a = next_id;
    send_pkt(2, 64, 128, 0);
    send_pkt(1, 32, 32, 32);
    t = 0;
    while (!cmpt_valid && t < 100) begin
      tick();
      t++;
    end
    chk("cmpt_valid_wait", cmpt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_cmpt_valid", cmpt_valid, 1);
      chk("hold_cmpt_len", cmpt_len, 128);
      chk("hold_cmpt_id", cmpt_pkt_id, 16'(id_a));
      chk("hold_no_tvalid", m_tvalid, 0);
      chk("hold_pkt_cnt", pkt_cnt, exp_pkts - 2);
    end
    cmpt_ready = 1'b1;
    tick();
    chk("pkt_cnt_released", pkt_cnt, exp_pkts - 1);
    tick();
    chk("next_pkt_tvalid", m_tvalid, 1);
    wait_idle();
    m_tready = 1'b0;
    send_beat(64, 1'b0);
    s_data = {16{32'hDEADBEEF}};
    s_ben = '1;
    s_valid = 1'b1;
    axi_areset = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_cmpt_valid", cmpt_valid, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0);
    chk("arst_byte_cnt", byte_cnt, 0);
    chk("arst_err", err_oversize, 0);
    chk("arst_m_len", m_len, 0);
    chk("arst_pkt_id", cmpt_pkt_id, 0);
    s_valid = 1'b0;
    pend.delete();
    exp_q.delete();
    cmp_q.delete();
    next_id = 0;
    exp_pkts = 0;
    exp_bytes = 0;
    repeat (2) tick();
    axi_areset = 1'b0;
    repeat (4) tick();
    m_tready = 1'b1;
    send_pkt(1, 64, 64, 0);
    wait_idle();
    chk("pkt_cnt_after_rst", pkt_cnt, 1);
    chk("byte_cnt_after_rst", byte_cnt, 64);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
